// File: rtl/irq_sequencer.sv
// Interrupt sequencer: latches edge/level IRQ lines into a pending vector and
// dispatches one ID at a time by round-robin through IDLE -> PRESENT -> ACTIVE.
module irq_sequencer #(
  parameter int IRQ_CNT = 32,
  parameter int IDW     = $clog2(IRQ_CNT)
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [IRQ_CNT-1:0] IRQ_IN,
  input  logic [IRQ_CNT-1:0] EDGE_SEL,
  input  logic [IRQ_CNT-1:0] IRQ_EN,
  output logic               IRQ_VALID,
  output logic [IDW-1:0]     IRQ_ID,
  input  logic               IRQ_ACK,
  input  logic               IRQ_EOI,
  output logic [IRQ_CNT-1:0] PENDING,
  output logic               BUSY,
  output logic [1:0]         STATE_DBG
);

  // Handshake: IRQ_VALID/IRQ_ID offer a request; IRQ_ACK is accepted only while
  // presenting and IRQ_EOI only while active, any other strobe is ignored.
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRESENT = 2'd1,
    S_ACTIVE  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [IRQ_CNT-1:0] in_q;
  logic [IRQ_CNT-1:0] pend_edge_q, pend_edge_d;
  logic [IRQ_CNT-1:0] edge_det, eligible, ack_clr;
  logic [IDW-1:0]     ptr_q, ptr_d, id_q, id_d, rr_sel;
  logic               rr_found, ack_acc;

  assign edge_det = IRQ_IN & ~in_q & EDGE_SEL;
  assign PENDING  = (pend_edge_q & EDGE_SEL) | (in_q & ~EDGE_SEL);
  assign eligible = PENDING & IRQ_EN;
  assign ack_acc  = (state_q == S_PRESENT) && IRQ_ACK;

  // A fresh edge in the same cycle as the acknowledging clear keeps the bit set.
  always_comb begin
    ack_clr = '0;
    if (ack_acc) ack_clr[id_q] = 1'b1;
    pend_edge_d = (pend_edge_q & ~ack_clr) | edge_det;
  end

  always_comb begin
    int idx;
    rr_sel   = ptr_q;
    rr_found = 1'b0;
    idx      = 0;
    for (int i = 0; i < IRQ_CNT; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= IRQ_CNT) idx = idx - IRQ_CNT;
      if (!rr_found && eligible[idx]) begin
        rr_found = 1'b1;
        rr_sel   = IDW'(idx);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      id_q        <= '0;
      in_q        <= '0;
      pend_edge_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      in_q        <= IRQ_IN;
      pend_edge_q <= pend_edge_d;
    end
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      S_IDLE: begin
        if (rr_found) begin
          state_d = S_PRESENT;
          id_d    = rr_sel;
        end
      end
      S_PRESENT: begin
        if (IRQ_ACK) begin
          state_d = S_ACTIVE;
          ptr_d   = (int'(id_q) == IRQ_CNT - 1) ? '0 : id_q + IDW'(1);
        end else if (!eligible[id_q]) begin
          state_d = S_IDLE;
        end
      end
      S_ACTIVE: begin
        if (IRQ_EOI) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    IRQ_VALID = (state_q == S_PRESENT);
    BUSY      = (state_q == S_ACTIVE);
    IRQ_ID    = id_q;
    STATE_DBG = state_q;
  end

endmodule

// File: tb/tb_irq_sequencer.sv
// Bench for irq_sequencer: directed vector table, hand-written corner sequences
// and randomized traffic, all compared against a queue/array-level reference model.
module tb_irq_sequencer;
  localparam int N   = 32;
  localparam int IDW = 5;

  logic           clk = 1'b0;
  logic           rst, ack, eoi;
  logic [N-1:0]   irq, es, en;
  logic           valid, busy;
  logic [IDW-1:0] id;
  logic [N-1:0]   pend;
  logic [1:0]     state_dbg;

  always #5 clk = ~clk;

  irq_sequencer #(.IRQ_CNT(N), .IDW(IDW)) dut (
    .CLK(clk), .RESET(rst), .IRQ_IN(irq), .EDGE_SEL(es), .IRQ_EN(en),
    .IRQ_VALID(valid), .IRQ_ID(id), .IRQ_ACK(ack), .IRQ_EOI(eoi),
    .PENDING(pend), .BUSY(busy), .STATE_DBG(state_dbg)
  );

  int n_pass = 0;
  int n_chk  = 0;

  // Reference model: mode 0 = nothing outstanding, 1 = offered, 2 = in service.
  logic [N-1:0] m_in, m_pe;
  int m_ptr, m_id, m_mode;

  function automatic logic [N-1:0] m_pending();
    return (m_pe & es) | (m_in & ~es);
  endfunction

  task automatic model_step();
    logic [N-1:0] elig, clr;
    clr = '0;
    if (rst) begin
      m_in = '0; m_pe = '0; m_ptr = 0; m_id = 0; m_mode = 0;
      return;
    end
    elig = m_pending() & en;
    case (m_mode)
      0: begin
        for (int k = 0; k < N; k++) begin
          if (elig[(m_ptr + k) % N]) begin
            m_mode = 1;
            m_id   = (m_ptr + k) % N;
            break;
          end
        end
      end
      1: begin
        if (ack) begin
          m_mode = 2;
          m_ptr  = (m_id + 1) % N;
          clr[m_id] = 1'b1;
        end else if (!elig[m_id]) begin
          m_mode = 0;
        end
      end
      default: if (eoi) m_mode = 0;
    endcase
    m_pe = (m_pe & ~clr) | (irq & ~m_in & es);
    m_in = irq;
  endtask

  task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    chk("valid",   N'(valid), N'(m_mode == 1));
    chk("busy",    N'(busy),  N'(m_mode == 2));
    chk("id",      N'(id),    N'(m_id));
    chk("pending", pend,      m_pending());
  endtask

  task automatic reset_dut();
    rst = 1'b1; ack = 1'b0; eoi = 1'b0; irq = '0;
    cycle();
    rst = 1'b0;
  endtask

  task automatic pulse(input logic [N-1:0] m);
    irq = irq | m;
    cycle();
    irq = irq & ~m;
    cycle();
  endtask

  task automatic wait_valid();
    for (int t = 0; t < 40 && !valid; t++) cycle();
    chk("wait_valid", N'(valid), N'(1'b1));
  endtask

  task automatic serve(output int got);
    wait_valid();
    got = int'(id);
    ack = 1'b1;
    cycle();
    ack = 1'b0;
    eoi = 1'b1;
    cycle();
    eoi = 1'b0;
  endtask

  typedef struct {
    logic         r;
    logic [N-1:0] i;
    logic         a;
    logic         e;
    logic         v;
    int           xid;
    logic         b;
    logic [N-1:0] p;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic [N-1:0] i, input logic a,
                              input logic e, input logic v, input int xid,
                              input logic b, input logic [N-1:0] p);
    vec_t t;
    t.r = r; t.i = i; t.a = a; t.e = e; t.v = v; t.xid = xid; t.b = b; t.p = p;
    return t;
  endfunction

  vec_t tbl[15];

  initial begin
    int got;
    logic [N-1:0] l3, l8;
    l3 = '0; l3[3] = 1'b1;
    l8 = 32'h8;
    //            rst  irq  ack  eoi  valid id busy pending
    tbl[0]  = mk(1'b1, '0, 1'b0, 1'b0, 1'b0, 0, 1'b0, '0);
    tbl[1]  = mk(1'b0, l3, 1'b0, 1'b0, 1'b0, 0, 1'b0, l8);
    tbl[2]  = mk(1'b0, '0, 1'b0, 1'b0, 1'b1, 3, 1'b0, l8);
    tbl[3]  = mk(1'b0, '0, 1'b0, 1'b0, 1'b1, 3, 1'b0, l8);
    tbl[4]  = mk(1'b0, '0, 1'b1, 1'b0, 1'b0, 3, 1'b1, '0);
    tbl[5]  = mk(1'b0, '0, 1'b0, 1'b0, 1'b0, 3, 1'b1, '0);
    tbl[6]  = mk(1'b0, '0, 1'b0, 1'b1, 1'b0, 3, 1'b0, '0);
    tbl[7]  = mk(1'b0, '0, 1'b0, 1'b0, 1'b0, 3, 1'b0, '0);
    tbl[8]  = mk(1'b0, '0, 1'b1, 1'b0, 1'b0, 3, 1'b0, '0);
    tbl[9]  = mk(1'b0, l3, 1'b0, 1'b0, 1'b0, 3, 1'b0, l8);
    tbl[10] = mk(1'b0, l3, 1'b0, 1'b0, 1'b1, 3, 1'b0, l8);
    tbl[11] = mk(1'b1, l3, 1'b1, 1'b0, 1'b0, 0, 1'b0, '0);
    tbl[12] = mk(1'b0, l3, 1'b0, 1'b0, 1'b0, 0, 1'b0, l8);
    tbl[13] = mk(1'b0, l3, 1'b0, 1'b0, 1'b1, 3, 1'b0, l8);
    tbl[14] = mk(1'b0, l3, 1'b0, 1'b1, 1'b1, 3, 1'b0, l8);

    rst = 1'b1; ack = 1'b0; eoi = 1'b0; irq = '0; es = '1; en = '1;
    m_in = '0; m_pe = '0; m_ptr = 0; m_id = 0; m_mode = 0;
    #2;

    for (int k = 0; k < 15; k++) begin
      rst = tbl[k].r; irq = tbl[k].i; ack = tbl[k].a; eoi = tbl[k].e;
      cycle();
      chk($sformatf("tbl%0d_valid", k), N'(valid), N'(tbl[k].v));
      chk($sformatf("tbl%0d_id", k),    N'(id),    N'(tbl[k].xid));
      chk($sformatf("tbl%0d_busy", k),  N'(busy),  N'(tbl[k].b));
      chk($sformatf("tbl%0d_pend", k),  pend,      tbl[k].p);
    end

    // Round-robin order and wrap.
    es = '1; en = '1;
    reset_dut();
    pulse((N'(1) << 1) | (N'(1) << 5) | (N'(1) << 30));
    serve(got); chk("rr_a0", N'(got), N'(1));
    serve(got); chk("rr_a1", N'(got), N'(5));
    serve(got); chk("rr_a2", N'(got), N'(30));
    pulse((N'(1) << 1) | (N'(1) << 30));
    serve(got); chk("rr_b0", N'(got), N'(1));
    serve(got); chk("rr_b1", N'(got), N'(30));
    pulse(N'(1) << 29);
    serve(got); chk("rr_c0", N'(got), N'(29));
    pulse((N'(1) << 1) | (N'(1) << 30));
    serve(got); chk("rr_d0", N'(got), N'(30));
    serve(got); chk("rr_d1", N'(got), N'(1));

    // Level line 7: re-presents while held, withdraws when dropped.
    es = '1; es[7] = 1'b0;
    reset_dut();
    irq[7] = 1'b1;
    serve(got); chk("lvl_first", N'(got), N'(7));
    wait_valid(); chk("lvl_again", N'(id), N'(7));
    irq[7] = 1'b0;
    cycle();
    cycle();
    chk("lvl_withdraw", N'(valid), N'(1'b0));
    pulse((N'(1) << 3) | (N'(1) << 9));
    serve(got); chk("lvl_ptr0", N'(got), N'(9));
    serve(got); chk("lvl_ptr1", N'(got), N'(3));

    // Edge during service of the same line, and edge coincident with ACK.
    es = '1;
    reset_dut();
    pulse(N'(1) << 2);
    wait_valid();
    ack = 1'b1; cycle(); ack = 1'b0;
    pulse(N'(1) << 2);
    chk("act_pend2", N'(pend[2]), N'(1'b1));
    chk("act_busy",  N'(busy),    N'(1'b1));
    eoi = 1'b1; cycle(); eoi = 1'b0;
    wait_valid(); chk("act_repres", N'(id), N'(2));
    irq[2] = 1'b1; ack = 1'b1;
    cycle();
    ack = 1'b0; irq[2] = 1'b0;
    chk("ackedge_pend2", N'(pend[2]), N'(1'b1));
    chk("ackedge_busy",  N'(busy),    N'(1'b1));

    // Reset while active overrides EOI and new edges.
    irq = N'(1) << 4; eoi = 1'b1; rst = 1'b1;
    cycle();
    chk("rst_valid", N'(valid), '0);
    chk("rst_busy",  N'(busy),  '0);
    chk("rst_id",    N'(id),    '0);
    chk("rst_pend",  pend,      '0);
    rst = 1'b0; eoi = 1'b0; irq = '0;

    // Randomized traffic against the model.
    reset_dut();
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) begin
        es = $urandom;
        en = $urandom | $urandom;
      end
      irq = irq ^ ($urandom & $urandom & $urandom);
      ack = ($urandom_range(0, 2) == 0);
      eoi = ($urandom_range(0, 3) == 0);
      rst = ($urandom_range(0, 499) == 0);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
